mem_wb_stage: RTL and testbench

MEM/WB pipeline stage of the MIPS datapath. It captures the ALU result, destination register and control bits from the MEM stage, and waits on the data-memory response for loads. It aligns and extends load data, then presents registered operands to the write-back select mux: ALU result on the select=0 input, memory data on the select=1 input. It also drives the register-file write controls.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/mem_wb_stage_if.sv | 36 +++
 rtl/load_align.sv | 55 +++++
 rtl/mem_wb_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: load encodings, MEM/WB FSM states and
// the hard-wired zero register number.
package mips_pkg;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LH  = 3'b001,
        LT_LHU = 3'b010,
        LT_LB  = 3'b011,
        LT_LBU = 3'b100
    } load_type_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic [31:0] extend8(input logic [7:0] b, input logic is_signed);
        return {{24{is_signed & b[7]}}, b};
    endfunction

    function automatic logic [31:0] extend16(input logic [15:0] h, input logic is_signed);
        return {{16{is_signed & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: upstream instruction handshake, data-memory response
// and write-back operands. The stage is the slave side.
interface mem_wb_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        mem_to_reg;
    logic [2:0]  load_type;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        wb_valid;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_mem_data;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_dest;
    logic        wb_reg_write;
    logic        misaligned;
    logic        mem_err;

    modport master (
        output flush, in_valid, alu_result, dest_reg, reg_write, mem_to_reg,
               load_type, mem_rdata, mem_rvalid,
        input  in_ready, wb_valid, wb_alu_result, wb_mem_data, wb_mem_to_reg,
               wb_dest, wb_reg_write, misaligned, mem_err
    );

    modport slave (
        input  flush, in_valid, alu_result, dest_reg, reg_write, mem_to_reg,
               load_type, mem_rdata, mem_rvalid,
        output in_ready, wb_valid, wb_alu_result, wb_mem_data, wb_mem_to_reg,
               wb_dest, wb_reg_write, misaligned, mem_err
    );
endinterface

// File: rtl/load_align.sv
// Big-endian load alignment: picks the byte/half-word addressed by the byte
// offset, extends it, and flags misaligned accesses (raw word passed through).
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  byte_offset,
    input  logic [2:0]  load_type,
    output logic [31:0] aligned_data,
    output logic        misaligned
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and extension by load type
    always_comb begin
        byte_s       = 8'h00;
        half_s       = 16'h0000;
        aligned_data = mem_rdata;
        misaligned   = 1'b0;

        case (byte_offset)
            2'd0:    byte_s = mem_rdata[31:24];
            2'd1:    byte_s = mem_rdata[23:16];
            2'd2:    byte_s = mem_rdata[15:8];
            default: byte_s = mem_rdata[7:0];
        endcase

        if (byte_offset[1]) begin
            half_s = mem_rdata[15:0];
        end else begin
            half_s = mem_rdata[31:16];
        end

        case (load_type)
            LT_LB:   aligned_data = extend8(byte_s, 1'b1);
            LT_LBU:  aligned_data = extend8(byte_s, 1'b0);
            LT_LH: begin
                misaligned   = byte_offset[0];
                aligned_data = byte_offset[0] ? mem_rdata : extend16(half_s, 1'b1);
            end
            LT_LHU: begin
                misaligned   = byte_offset[0];
                aligned_data = byte_offset[0] ? mem_rdata : extend16(half_s, 1'b0);
            end
            // LW and every unused encoding behave as a word load
            default: begin
                misaligned   = (byte_offset != 2'd0);
                aligned_data = mem_rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: waits on the data-memory response for loads,
// aligns load data and presents registered write-back operands.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] lat_alu_q, lat_alu_d;
    logic [4:0]  lat_dest_q, lat_dest_d;
    logic        lat_rw_q, lat_rw_d;
    logic [2:0]  lat_lt_q, lat_lt_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_m2r_q, wb_m2r_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic        wb_rw_q, wb_rw_d;
    logic        mis_q, mis_d;
    logic        mem_err_q, mem_err_d;

    logic        sel_wait_s;
    logic [31:0] src_alu_s;
    logic [4:0]  src_dest_s;
    logic        src_rw_s;
    logic        src_m2r_s;
    logic [2:0]  src_lt_s;
    logic [31:0] align_data_s;
    logic        align_mis_s;
    logic        finish_s;
    logic        timeout_s;

    // A completing load takes its fields from the latch while waiting,
    // otherwise straight from the MEM stage.
    assign sel_wait_s = (state_q == ST_WAIT_MEM);
    assign src_alu_s  = sel_wait_s ? lat_alu_q  : bus.alu_result;
    assign src_dest_s = sel_wait_s ? lat_dest_q : bus.dest_reg;
    assign src_rw_s   = sel_wait_s ? lat_rw_q   : bus.reg_write;
    assign src_m2r_s  = sel_wait_s ? 1'b1       : bus.mem_to_reg;
    assign src_lt_s   = sel_wait_s ? lat_lt_q   : bus.load_type;

    load_align u_load_align (
        .mem_rdata    (bus.mem_rdata),
        .byte_offset  (src_alu_s[1:0]),
        .load_type    (src_lt_s),
        .aligned_data (align_data_s),
        .misaligned   (align_mis_s)
    );

    // Next-state, latch and write-back operand computation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_alu_d  = lat_alu_q;
        lat_dest_d = lat_dest_q;
        lat_rw_d   = lat_rw_q;
        lat_lt_d   = lat_lt_q;
        wb_valid_d = 1'b0;
        wb_alu_d   = wb_alu_q;
        wb_data_d  = wb_data_q;
        wb_m2r_d   = wb_m2r_q;
        wb_dest_d  = wb_dest_q;
        wb_rw_d    = 1'b0;
        mis_d      = 1'b0;
        mem_err_d  = mem_err_q;
        finish_s   = 1'b0;
        timeout_s  = 1'b0;

        if (bus.flush) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_W'(0);
        end else if (state_q == ST_IDLE) begin
            if (bus.in_valid) begin
                lat_alu_d  = bus.alu_result;
                lat_dest_d = bus.dest_reg;
                lat_rw_d   = bus.reg_write;
                lat_lt_d   = bus.load_type;
                if (!bus.mem_to_reg || bus.mem_rvalid) begin
                    finish_s = 1'b1;
                end else begin
                    state_d = ST_WAIT_MEM;
                    cnt_d   = CNT_W'(0);
                end
            end else begin
                cnt_d = CNT_W'(0);
            end
        end else begin
            if (bus.mem_rvalid) begin
                finish_s = 1'b1;
                state_d  = ST_IDLE;
                cnt_d    = CNT_W'(0);
            end else if (cnt_q == TMO_LAST) begin
                timeout_s = 1'b1;
                state_d   = ST_IDLE;
                cnt_d     = CNT_W'(0);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (finish_s) begin
            wb_valid_d = 1'b1;
            wb_alu_d   = src_alu_s;
            wb_dest_d  = src_dest_s;
            wb_m2r_d   = src_m2r_s;
            if (src_m2r_s) begin
                mis_d     = align_mis_s;
                wb_data_d = align_data_s;
                wb_rw_d   = src_rw_s && (src_dest_s != REG_ZERO) && !align_mis_s;
            end else begin
                wb_data_d = 32'h0000_0000;
                wb_rw_d   = src_rw_s && (src_dest_s != REG_ZERO);
            end
        end else if (timeout_s) begin
            wb_valid_d = 1'b1;
            wb_alu_d   = lat_alu_q;
            wb_dest_d  = lat_dest_q;
            wb_m2r_d   = 1'b1;
            wb_data_d  = ERR_DATA;
            mem_err_d  = 1'b1;
        end else begin
            wb_valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_W'(0);
            lat_alu_q  <= 32'h0000_0000;
            lat_dest_q <= 5'd0;
            lat_rw_q   <= 1'b0;
            lat_lt_q   <= 3'd0;
            wb_valid_q <= 1'b0;
            wb_alu_q   <= 32'h0000_0000;
            wb_data_q  <= 32'h0000_0000;
            wb_m2r_q   <= 1'b0;
            wb_dest_q  <= 5'd0;
            wb_rw_q    <= 1'b0;
            mis_q      <= 1'b0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_alu_q  <= lat_alu_d;
            lat_dest_q <= lat_dest_d;
            lat_rw_q   <= lat_rw_d;
            lat_lt_q   <= lat_lt_d;
            wb_valid_q <= wb_valid_d;
            wb_alu_q   <= wb_alu_d;
            wb_data_q  <= wb_data_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_dest_q  <= wb_dest_d;
            wb_rw_q    <= wb_rw_d;
            mis_q      <= mis_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign bus.in_ready      = (state_q == ST_IDLE);
    assign bus.wb_valid      = wb_valid_q;
    assign bus.wb_alu_result = wb_alu_q;
    assign bus.wb_mem_data   = wb_data_q;
    assign bus.wb_mem_to_reg = wb_m2r_q;
    assign bus.wb_dest       = wb_dest_q;
    assign bus.wb_reg_write  = wb_rw_q;
    assign bus.misaligned    = mis_q;
    assign bus.mem_err       = mem_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed plan cases plus randomized
// transactions checked against a byte-lane arithmetic reference model.
module tb_mem_wb_stage;

    localparam int          TMO = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] data;
        logic [4:0]  dest;
        logic        m2r;
        logic        rw;
        logic        mis;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   exp_err = 1'b0;
    exp_t exp_q[$];
    exp_t mon_e;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: pick the addressed byte/half of a big-endian word arithmetically
    function automatic exp_t model(input logic [31:0] alu, input logic [4:0] dest,
                                   input logic rw, input logic m2r, input logic [2:0] lt,
                                   input logic [31:0] rd, input bit tmo, input bit err);
        exp_t        e;
        int          off;
        logic [31:0] b;
        logic [31:0] h;
        e.alu = alu; e.dest = dest; e.m2r = m2r; e.err = err;
        e.mis = 1'b0; e.data = 32'h0; e.rw = 1'b0;
        off = int'(alu[1:0]);
        b = (rd >> (8 * (3 - off))) & 32'hFF;
        h = (rd >> (16 * (1 - off / 2))) & 32'hFFFF;
        if (!m2r) begin
            e.rw = rw && (dest != 5'd0);
        end else if (tmo) begin
            e.data = ERR;
        end else begin
            case (lt)
                3'd1:    if (off % 2 == 1) e.mis = 1'b1; else e.data = (h >= 32'h8000) ? h - 32'h1_0000 : h;
                3'd2:    if (off % 2 == 1) e.mis = 1'b1; else e.data = h;
                3'd3:    e.data = (b >= 32'h80) ? b - 32'h100 : b;
                3'd4:    e.data = b;
                default: if (off != 0) e.mis = 1'b1; else e.data = rd;
            endcase
            if (e.mis) e.data = rd;
            e.rw = rw && (dest != 5'd0) && !e.mis;
        end
        return e;
    endfunction

    // dly: 0 = response with the request, n > 0 = n stall cycles, -1 = never
    task automatic run_tx(input logic [31:0] alu, input logic [4:0] dest, input logic rw,
                          input logic m2r, input logic [2:0] lt, input logic [31:0] rd,
                          input int dly, input exp_t e);
        int n;
        exp_q.push_back(e);
        bus.in_valid   = 1'b1;
        bus.alu_result = alu;
        bus.dest_reg   = dest;
        bus.reg_write  = rw;
        bus.mem_to_reg = m2r;
        bus.load_type  = lt;
        bus.mem_rdata  = rd;
        bus.mem_rvalid = m2r && (dly == 0);
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.alu_result = $urandom;
        bus.load_type  = 3'($urandom_range(0, 7));
        bus.dest_reg   = 5'($urandom_range(0, 31));
        if (m2r && dly != 0) begin
            n = (dly < 0) ? TMO : dly;
            for (int k = 0; k < n; k++) begin
                chk("wait_in_ready", {31'b0, bus.in_ready}, 32'd0);
                if (dly > 0 && k == n - 1) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rd;
                end else begin
                    bus.mem_rdata  = $urandom;
                end
                @(posedge clk); #1;
                bus.mem_rvalid = 1'b0;
            end
            chk("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wb_valid"}, {31'b0, bus.wb_valid}, 32'd0);
        chk({tag, "_wb_alu"}, bus.wb_alu_result, 32'd0);
        chk({tag, "_wb_data"}, bus.wb_mem_data, 32'd0);
        chk({tag, "_wb_dest"}, {27'b0, bus.wb_dest}, 32'd0);
        chk({tag, "_wb_m2r"}, {31'b0, bus.wb_mem_to_reg}, 32'd0);
        chk({tag, "_wb_rw"}, {31'b0, bus.wb_reg_write}, 32'd0);
        chk({tag, "_misaligned"}, {31'b0, bus.misaligned}, 32'd0);
        chk({tag, "_mem_err"}, {31'b0, bus.mem_err}, 32'd0);
        chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    // Monitor: every write-back must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wb_alu_result", bus.wb_alu_result, mon_e.alu);
                    chk("wb_mem_data", bus.wb_mem_data, mon_e.data);
                    chk("wb_dest", {27'b0, bus.wb_dest}, {27'b0, mon_e.dest});
                    chk("wb_mem_to_reg", {31'b0, bus.wb_mem_to_reg}, {31'b0, mon_e.m2r});
                    chk("wb_reg_write", {31'b0, bus.wb_reg_write}, {31'b0, mon_e.rw});
                    chk("misaligned", {31'b0, bus.misaligned}, {31'b0, mon_e.mis});
                    chk("mem_err", {31'b0, bus.mem_err}, {31'b0, mon_e.err});
                end
            end else begin
                chk("bubble_reg_write", {31'b0, bus.wb_reg_write}, 32'd0);
                chk("bubble_misaligned", {31'b0, bus.misaligned}, 32'd0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] alu, rd;
        logic [4:0]  dest;
        logic        rw, m2r;
        logic [2:0]  lt;
        int          dly, r;

        rst = 1'b1;
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.alu_result = 32'h0;
        bus.dest_reg = 5'd0; bus.reg_write = 1'b0; bus.mem_to_reg = 1'b0;
        bus.load_type = 3'd0; bus.mem_rdata = 32'h0; bus.mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed plan cases
        run_tx(32'h0000_0010, 5'd5, 1'b1, 1'b0, 3'd0, 32'h0, 0,
               '{alu: 32'h10, data: 32'h0, dest: 5'd5, m2r: 1'b0, rw: 1'b1, mis: 1'b0, err: 1'b0});
        run_tx(32'h0000_1001, 5'd7, 1'b1, 1'b1, 3'd3, 32'h1280_3456, 0,
               '{alu: 32'h1001, data: 32'hFFFF_FF80, dest: 5'd7, m2r: 1'b1, rw: 1'b1, mis: 1'b0, err: 1'b0});
        run_tx(32'h0000_1001, 5'd7, 1'b1, 1'b1, 3'd4, 32'h1280_3456, 0,
               '{alu: 32'h1001, data: 32'h0000_0080, dest: 5'd7, m2r: 1'b1, rw: 1'b1, mis: 1'b0, err: 1'b0});
        run_tx(32'h0000_2002, 5'd9, 1'b1, 1'b1, 3'd1, 32'hAAAA_8001, 3,
               '{alu: 32'h2002, data: 32'hFFFF_8001, dest: 5'd9, m2r: 1'b1, rw: 1'b1, mis: 1'b0, err: 1'b0});
        run_tx(32'h0000_2002, 5'd10, 1'b1, 1'b1, 3'd0, 32'h1234_5678, 0,
               '{alu: 32'h2002, data: 32'h1234_5678, dest: 5'd10, m2r: 1'b1, rw: 1'b0, mis: 1'b1, err: 1'b0});
        run_tx(32'h0000_3000, 5'd0, 1'b1, 1'b1, 3'd0, 32'hCAFE_F00D, 1,
               '{alu: 32'h3000, data: 32'hCAFE_F00D, dest: 5'd0, m2r: 1'b1, rw: 1'b0, mis: 1'b0, err: 1'b0});
        run_tx(32'h0000_5000, 5'd12, 1'b1, 1'b1, 3'd2, 32'h8765_4321, 16,
               '{alu: 32'h5000, data: 32'h0000_8765, dest: 5'd12, m2r: 1'b1, rw: 1'b1, mis: 1'b0, err: 1'b0});
        exp_err = 1'b1;
        run_tx(32'h0000_4000, 5'd11, 1'b1, 1'b1, 3'd0, 32'h0, -1,
               '{alu: 32'h4000, data: ERR, dest: 5'd11, m2r: 1'b1, rw: 1'b0, mis: 1'b0, err: 1'b1});

        // Flush while waiting, coincident with the memory response
        bus.in_valid = 1'b1; bus.mem_to_reg = 1'b1; bus.reg_write = 1'b1;
        bus.dest_reg = 5'd3; bus.load_type = 3'd0; bus.alu_result = 32'h100;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        chk("stale_rvalid_in_ready", {31'b0, bus.in_ready}, 32'd1);
        // Flush kills an instruction accepted in the same cycle
        bus.in_valid = 1'b1; bus.mem_to_reg = 1'b0; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;

        for (int i = 0; i < 60; i++) begin
            alu  = $urandom;
            dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rw   = ($urandom_range(0, 3) != 0);
            m2r  = ($urandom_range(0, 2) != 0);
            lt   = 3'($urandom_range(0, 7));
            rd   = $urandom;
            r    = $urandom_range(0, 9);
            dly  = (r < 4) ? 0 : ((r == 9) ? -1 : $urandom_range(1, TMO));
            if (m2r && dly < 0) exp_err = 1'b1;
            run_tx(alu, dest, rw, m2r, lt, rd, dly, model(alu, dest, rw, m2r, lt, rd, dly < 0, exp_err));
            repeat ($urandom_range(0, 2)) begin
                bus.mem_rvalid = 1'($urandom_range(0, 1));
                bus.mem_rdata  = $urandom;
                @(posedge clk); #1;
                bus.mem_rvalid = 1'b0;
            end
        end

        // Reset in the middle of a wait, then a stale response
        bus.in_valid = 1'b1; bus.mem_to_reg = 1'b1; bus.reg_write = 1'b1;
        bus.dest_reg = 5'd4; bus.load_type = 3'd0; bus.alu_result = 32'h200;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        exp_err = 1'b0;
        @(negedge clk);
        check_all_zero("midwait_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        chk("post_reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        run_tx(32'h0000_0044, 5'd31, 1'b1, 1'b0, 3'd0, 32'h0, 0,
               '{alu: 32'h44, data: 32'h0, dest: 5'd31, m2r: 1'b0, rw: 1'b1, mis: 1'b0, err: 1'b0});

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
